wash_phase_scheduler: RTL and testbench
=======================================

Name: wash_phase_scheduler

Overview:
- Sequences one complete laundry program: lock, fill, optional heat, timed agitation, drain, spin, then 0–3 rinse passes (fill/agitate/drain/spin) before completion.
- Owns all actuator enables and phase/fault timeouts; sits between the user-input/mode decode logic and the actuator drivers.
- Timing counts an external 1 Hz `tick` strobe, so counters stay narrow.

Parameters:
- TIMER_W, 12, phase timer width; timer saturates at all-ones.
- LEVEL_FULL, 10'd512, water_level at or above this = full.
- LEVEL_EMPTY, 10'd16, water_level at or below this = empty.
- FILL_TIMEOUT, 120, ticks allowed in FILL.
- HEAT_TIMEOUT, 900, ticks allowed in HEAT.
- DRAIN_TIMEOUT, 90, ticks allowed in DRAIN or ABORT_DRAIN.
- WASH_TIME, 600, agitate ticks on pass 0.
- RINSE_TIME, 180, agitate ticks on passes ≥1.
- SPIN_TIME, 360, spin ticks per pass.
- AGIT_ON, 12, drum-on ticks per agitation half-cycle.
- AGIT_OFF, 3, drum-off ticks between direction reversals.
- REBAL_TIME, 20, tumble ticks in REBALANCE.
- MAX_RETRY, 3, rebalance attempts allowed per spin.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  1 Hz single-cycle enable
- start  in  1  begin program (level sampled in IDLE)
- pause  in  1  freeze program while high
- abort  in  1  cancel program and drain
- clear  in  1  acknowledge DONE/FAULT
- door_closed  in  1  door switch
- heat_req  in  1  heat required (sampled at start)
- rinse_cnt  in  2  extra rinse passes (sampled at start)
- water_level  in  10  level ADC
- temp_reached  in  1  temperature at or above target
- vibration  in  1  unbalance detected
- fill_en  out  1  water valve
- heat_en  out  1  heater
- drum_en  out  1  drum motor on, wash speed
- drum_dir  out  1  0 = CW, 1 = CCW
- spin_en  out  1  drum at spin speed
- drain_en  out  1  drain pump
- door_lock  out  1  door lock solenoid
- done  out  1  program complete
- fault  out  1  fault latched
- fault_code  out  3  1 fill timeout, 2 heat timeout, 3 drain timeout, 4 unbalance, 5 door opened
- phase  out  4  current state encoding

Behaviour:
- Reset values: all outputs 0; state IDLE; all timers, pass, retry and config registers cleared.
- Outputs are registered and update on the same edge the state changes.

Timers:
- Phase timer clears on every state entry.
- Phase timer increments on `tick` only when not paused, and saturates.
- Expiry condition is timer ≥ limit, evaluated every clk.

State machine (phase encoding 0–9):
- IDLE (0): on `start` & `door_closed`, latch heat_req/rinse_cnt, set pass = 0, go to FILL. `start` with door open is ignored.
- FILL (1): fill_en = 1, door_lock = 1.
  - water_level ≥ LEVEL_FULL → HEAT if (heat_cfg & pass == 0), else AGITATE.
  - Timeout → FAULT code 1.
- HEAT (2): heat_en = 1; drum runs the agitation pattern.
  - temp_reached → AGITATE.
  - Timeout → FAULT code 2.
- AGITATE (3): sub-counter pattern, counted in ticks:
  - drum_en = 1 with drum_dir = 0 for AGIT_ON ticks;
  - drum off for AGIT_OFF ticks;
  - drum_en = 1 with drum_dir = 1 for AGIT_ON ticks;
  - drum off for AGIT_OFF ticks; repeat.
  - Exit to DRAIN when timer ≥ WASH_TIME (pass 0) or ≥ RINSE_TIME (pass ≥ 1).
- DRAIN (4): drain_en = 1.
  - water_level ≤ LEVEL_EMPTY → SPIN with retry = 0.
  - Timeout → FAULT code 3.
- SPIN (5): spin_en = 1, drain_en = 1.
  - Timer ≥ SPIN_TIME: if pass < rinse_cfg, increment pass and go to FILL; else go to DONE.
  - vibration → REBALANCE.
- REBALANCE (6): drum_en = 1, drum_dir alternates every tick, spin_en = 0.
  - After REBAL_TIME ticks: retry + 1; if retry == MAX_RETRY → FAULT code 4, else SPIN with the spin timer restarted.
- DONE (7): done = 1, door_lock = 0, all actuators off; `clear` → IDLE.
- FAULT (8): fault = 1, fault_code held.
  - drain_en = 1 and door_lock = 1 while water_level > LEVEL_EMPTY.
  - `clear` → IDLE only when water_level ≤ LEVEL_EMPTY, clearing fault and fault_code.
- ABORT_DRAIN (9): drain_en = 1, door_lock = 1.
  - water_level ≤ LEVEL_EMPTY → IDLE with no fault.
  - Timeout → FAULT code 3.

Priority in active states (1–6), highest first:
1. abort → ABORT_DRAIN.
2. !door_closed → FAULT code 5.
3. vibration (SPIN only).
4. pause.
5. Normal transitions.

Pause:
- While `pause` is high, all actuators are 0, door_lock = 1, and state, timers, sub-counter and pass are frozen.
- On pause deassert, the program resumes in the same state with preserved counts.
- `pause` is ignored in IDLE, DONE, FAULT and ABORT_DRAIN.

Simultaneous events:
- `tick` on the same cycle as a state entry does not increment the new state's timer.
- Fill-full and fill-timeout on the same cycle: full wins.

Reset mid-operation: immediate return to IDLE with all actuators off.

Test Plan:
1. Bench parameters WASH_TIME = 20, RINSE_TIME = 10, SPIN_TIME = 8, AGIT_ON = 4, AGIT_OFF = 1. Run start with door_closed, heat_req = 0, rinse_cnt = 1; level ramped to 512 and dropped to 0 at each phase → phase sequence 1,3,4,5,1,3,4,5,7; done = 1; drum_dir toggles every 5 ticks in AGITATE.
2. heat_req = 1 with temp_reached held low → HEAT for HEAT_TIMEOUT ticks, then phase 8, fault_code = 2, heat_en = 0; drain_en = 1 until level ≤ 16; `clear` → phase 0.
3. vibration pulsed at SPIN tick 3, three times → REBALANCE entered three times, third exit to FAULT code 4. With only two pulses → completes normally.
4. pause asserted at AGITATE timer = 7 for 50 ticks → all actuators 0, door_lock = 1, timer stays 7; after release, AGITATE exits after exactly 13 more ticks.
5. abort during FILL at level 300 → phase 9, fill_en = 0, drain_en = 1. Level drops to 10 → phase 0, fault = 0, door_lock = 0.
6. door_closed dropped in AGITATE → FAULT code 5 on the next clk. Reset asserted low mid-SPIN → all outputs 0 and phase 0 asynchronously.

Source files
------------

// File: rtl/wash_phase_scheduler.sv
// Laundry program sequencer: lock, fill, optional heat, agitate, drain, spin,
// then up to three rinse passes. All timing counts an external 1 Hz tick.
module wash_phase_scheduler #(
    parameter int          TIMER_W       = 12,
    parameter logic [9:0]  LEVEL_FULL    = 10'd512,
    parameter logic [9:0]  LEVEL_EMPTY   = 10'd16,
    parameter int          FILL_TIMEOUT  = 120,
    parameter int          HEAT_TIMEOUT  = 900,
    parameter int          DRAIN_TIMEOUT = 90,
    parameter int          WASH_TIME     = 600,
    parameter int          RINSE_TIME    = 180,
    parameter int          SPIN_TIME     = 360,
    parameter int          AGIT_ON       = 12,
    parameter int          AGIT_OFF      = 3,
    parameter int          REBAL_TIME    = 20,
    parameter int          MAX_RETRY     = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_abort,
    input  logic       i_clear,
    input  logic       i_door_closed,
    input  logic       i_heat_req,
    input  logic [1:0] i_rinse_cnt,
    input  logic [9:0] i_water_level,
    input  logic       i_temp_reached,
    input  logic       i_vibration,
    output logic       o_fill_en,
    output logic       o_heat_en,
    output logic       o_drum_en,
    output logic       o_drum_dir,
    output logic       o_spin_en,
    output logic       o_drain_en,
    output logic       o_door_lock,
    output logic       o_done,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [3:0] o_phase
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FILL      = 4'd1,
        S_HEAT      = 4'd2,
        S_AGITATE   = 4'd3,
        S_DRAIN     = 4'd4,
        S_SPIN      = 4'd5,
        S_REBALANCE = 4'd6,
        S_DONE      = 4'd7,
        S_FAULT     = 4'd8,
        S_ABORT     = 4'd9
    } state_t;

    localparam logic [TIMER_W-1:0] L_FILL  = TIMER_W'(FILL_TIMEOUT);
    localparam logic [TIMER_W-1:0] L_HEAT  = TIMER_W'(HEAT_TIMEOUT);
    localparam logic [TIMER_W-1:0] L_DRAIN = TIMER_W'(DRAIN_TIMEOUT);
    localparam logic [TIMER_W-1:0] L_WASH  = TIMER_W'(WASH_TIME);
    localparam logic [TIMER_W-1:0] L_RINSE = TIMER_W'(RINSE_TIME);
    localparam logic [TIMER_W-1:0] L_SPIN  = TIMER_W'(SPIN_TIME);
    localparam logic [TIMER_W-1:0] L_REBAL = TIMER_W'(REBAL_TIME);

    // One agitation cycle: CW on, off, CCW on, off.
    localparam int               AGIT_CYC = 2 * (AGIT_ON + AGIT_OFF);
    localparam int               SUB_W    = $clog2(AGIT_CYC + 1);
    localparam logic [SUB_W-1:0] SUB_ON   = SUB_W'(AGIT_ON);
    localparam logic [SUB_W-1:0] SUB_REV  = SUB_W'(AGIT_ON + AGIT_OFF);
    localparam logic [SUB_W-1:0] SUB_ON2  = SUB_W'(2 * AGIT_ON + AGIT_OFF);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(AGIT_CYC - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    state_t             r_state, w_state_next;
    logic [TIMER_W-1:0] r_timer, w_timer_next;
    logic [SUB_W-1:0]   r_sub, w_sub_next;
    logic [1:0]         r_pass, w_pass_next;
    logic [3:0]         r_retry, w_retry_next;
    logic               r_heat_cfg, w_heat_cfg_next;
    logic [1:0]         r_rinse_cfg, w_rinse_cfg_next;
    logic [2:0]         r_fault_code, w_fault_code_next;

    logic r_fill_en, r_heat_en, r_drum_en, r_drum_dir, r_spin_en;
    logic r_drain_en, r_door_lock, r_done, r_fault;
    logic w_fill_en, w_heat_en, w_drum_en, w_drum_dir, w_spin_en;
    logic w_drain_en, w_door_lock, w_done, w_fault;

    logic w_active, w_hold, w_entry, w_count, w_full, w_empty;
    logic [TIMER_W-1:0] w_agit_limit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_sub        <= '0;
            r_pass       <= '0;
            r_retry      <= '0;
            r_heat_cfg   <= 1'b0;
            r_rinse_cfg  <= '0;
            r_fault_code <= '0;
            r_fill_en    <= 1'b0;
            r_heat_en    <= 1'b0;
            r_drum_en    <= 1'b0;
            r_drum_dir   <= 1'b0;
            r_spin_en    <= 1'b0;
            r_drain_en   <= 1'b0;
            r_door_lock  <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_sub        <= w_sub_next;
            r_pass       <= w_pass_next;
            r_retry      <= w_retry_next;
            r_heat_cfg   <= w_heat_cfg_next;
            r_rinse_cfg  <= w_rinse_cfg_next;
            r_fault_code <= w_fault_code_next;
            r_fill_en    <= w_fill_en;
            r_heat_en    <= w_heat_en;
            r_drum_en    <= w_drum_en;
            r_drum_dir   <= w_drum_dir;
            r_spin_en    <= w_spin_en;
            r_drain_en   <= w_drain_en;
            r_door_lock  <= w_door_lock;
            r_done       <= w_done;
            r_fault      <= w_fault;
        end
    end

    assign w_full       = (i_water_level >= LEVEL_FULL);
    assign w_empty      = (i_water_level <= LEVEL_EMPTY);
    assign w_agit_limit = (r_pass == 2'd0) ? L_WASH : L_RINSE;
    assign w_active     = (r_state >= S_FILL) && (r_state <= S_REBALANCE);
    // Pause only freezes when nothing of higher priority is pending.
    assign w_hold = w_active && i_pause && !i_abort && i_door_closed &&
                    !((r_state == S_SPIN) && i_vibration);

    always_comb begin
        w_state_next      = r_state;
        w_pass_next       = r_pass;
        w_retry_next      = r_retry;
        w_heat_cfg_next   = r_heat_cfg;
        w_rinse_cfg_next  = r_rinse_cfg;
        w_fault_code_next = r_fault_code;

        if (w_active && i_abort) begin
            w_state_next = S_ABORT;
        end else if (w_active && !i_door_closed) begin
            w_state_next      = S_FAULT;
            w_fault_code_next = 3'd5;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_door_closed) begin
                        w_heat_cfg_next  = i_heat_req;
                        w_rinse_cfg_next = i_rinse_cnt;
                        w_pass_next      = 2'd0;
                        w_state_next     = S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_full) begin
                        w_state_next = (r_heat_cfg && (r_pass == 2'd0)) ? S_HEAT : S_AGITATE;
                    end else if (r_timer >= L_FILL) begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = 3'd1;
                    end
                end
                S_HEAT: begin
                    if (i_temp_reached) begin
                        w_state_next = S_AGITATE;
                    end else if (r_timer >= L_HEAT) begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = 3'd2;
                    end
                end
                S_AGITATE: begin
                    if (r_timer >= w_agit_limit) w_state_next = S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        w_state_next = S_SPIN;
                        w_retry_next = '0;
                    end else if (r_timer >= L_DRAIN) begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = 3'd3;
                    end
                end
                S_SPIN: begin
                    if (i_vibration) begin
                        w_state_next = S_REBALANCE;
                    end else if (r_timer >= L_SPIN) begin
                        if (r_pass < r_rinse_cfg) begin
                            w_pass_next  = r_pass + 2'd1;
                            w_state_next = S_FILL;
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end
                end
                S_REBALANCE: begin
                    if (r_timer >= L_REBAL) begin
                        w_retry_next = r_retry + 4'd1;
                        if (w_retry_next == RETRY_MAX) begin
                            w_state_next      = S_FAULT;
                            w_fault_code_next = 3'd4;
                        end else begin
                            w_state_next = S_SPIN;
                        end
                    end
                end
                S_DONE: begin
                    if (i_clear) w_state_next = S_IDLE;
                end
                S_FAULT: begin
                    if (i_clear && w_empty) begin
                        w_state_next      = S_IDLE;
                        w_fault_code_next = 3'd0;
                    end
                end
                S_ABORT: begin
                    if (w_empty) begin
                        w_state_next = S_IDLE;
                    end else if (r_timer >= L_DRAIN) begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = 3'd3;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // A tick landing on a state entry is swallowed: the new state starts at 0.
    assign w_entry = (w_state_next != r_state);
    assign w_count = i_tick && !w_hold && !w_entry;

    always_comb begin
        w_timer_next = r_timer;
        w_sub_next   = r_sub;
        if (w_entry) begin
            w_timer_next = '0;
            w_sub_next   = '0;
        end else if (w_count) begin
            if (r_timer != {TIMER_W{1'b1}}) w_timer_next = r_timer + 1'b1;
            if ((r_state == S_HEAT) || (r_state == S_AGITATE))
                w_sub_next = (r_sub == SUB_LAST) ? '0 : r_sub + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_comb begin
        w_fill_en   = 1'b0;
        w_heat_en   = 1'b0;
        w_drum_en   = 1'b0;
        w_drum_dir  = 1'b0;
        w_spin_en   = 1'b0;
        w_drain_en  = 1'b0;
        w_door_lock = 1'b0;
        w_done      = 1'b0;
        w_fault     = 1'b0;
        if (w_hold) begin
            w_door_lock = 1'b1;
        end else begin
            case (w_state_next)
                S_FILL: begin
                    w_fill_en   = 1'b1;
                    w_door_lock = 1'b1;
                end
                S_HEAT, S_AGITATE: begin
                    w_heat_en   = (w_state_next == S_HEAT);
                    w_door_lock = 1'b1;
                    w_drum_en   = (w_sub_next < SUB_ON) ||
                                  ((w_sub_next >= SUB_REV) && (w_sub_next < SUB_ON2));
                    w_drum_dir  = (w_sub_next >= SUB_REV);
                end
                S_DRAIN, S_ABORT: begin
                    w_drain_en  = 1'b1;
                    w_door_lock = 1'b1;
                end
                S_SPIN: begin
                    w_spin_en   = 1'b1;
                    w_drain_en  = 1'b1;
                    w_door_lock = 1'b1;
                end
                S_REBALANCE: begin
                    w_drum_en   = 1'b1;
                    w_drum_dir  = w_timer_next[0];
                    w_door_lock = 1'b1;
                end
                S_DONE: w_done = 1'b1;
                S_FAULT: begin
                    w_fault     = 1'b1;
                    w_drain_en  = !w_empty;
                    w_door_lock = !w_empty;
                end
                default: ;
            endcase
        end
    end

    assign o_fill_en    = r_fill_en;
    assign o_heat_en    = r_heat_en;
    assign o_drum_en    = r_drum_en;
    assign o_drum_dir   = r_drum_dir;
    assign o_spin_en    = r_spin_en;
    assign o_drain_en   = r_drain_en;
    assign o_door_lock  = r_door_lock;
    assign o_done       = r_done;
    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;
    assign o_phase      = r_state;

endmodule

// File: tb/tb_wash_phase_scheduler.sv
// Directed bench for wash_phase_scheduler with shortened phase times.
module tb_wash_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0, clear = 1'b0;
    logic       door_closed = 1'b0, heat_req = 1'b0, temp_reached = 1'b0, vibration = 1'b0;
    logic [1:0] rinse_cnt = 2'd0;
    logic [9:0] level = 10'd0;
    logic       fill_en, heat_en, drum_en, drum_dir, spin_en, drain_en, door_lock, done, fault;
    logic [2:0] fault_code;
    logic [3:0] phase;

    int n_assert = 0;
    int n_fail   = 0;

    wash_phase_scheduler #(
        .FILL_TIMEOUT(30), .HEAT_TIMEOUT(40), .DRAIN_TIMEOUT(20),
        .WASH_TIME(20), .RINSE_TIME(10), .SPIN_TIME(8),
        .AGIT_ON(4), .AGIT_OFF(1), .REBAL_TIME(5), .MAX_RETRY(3)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start), .i_pause(pause),
        .i_abort(abort), .i_clear(clear), .i_door_closed(door_closed), .i_heat_req(heat_req),
        .i_rinse_cnt(rinse_cnt), .i_water_level(level), .i_temp_reached(temp_reached),
        .i_vibration(vibration), .o_fill_en(fill_en), .o_heat_en(heat_en), .o_drum_en(drum_en),
        .o_drum_dir(drum_dir), .o_spin_en(spin_en), .o_drain_en(drain_en), .o_door_lock(door_lock),
        .o_done(done), .o_fault(fault), .o_fault_code(fault_code), .o_phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    // Starts a no-heat, no-rinse program and runs it into SPIN.
    task automatic run_to_spin();
        heat_req = 1'b0; rinse_cnt = 2'd0; level = 10'd0;
        do_start();
        level = 10'd512; cyc(1);
        ticks(20); cyc(1);
        level = 10'd0; cyc(1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_phase", phase, 0);
        chk("rst_outputs", {fill_en, heat_en, drum_en, drum_dir, spin_en, drain_en, door_lock, done, fault, fault_code}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);

        // Start with door open is ignored
        do_start();
        chk("door_open_start", phase, 0);

        // Normal program, one rinse pass
        door_closed = 1'b1; rinse_cnt = 2'd1;
        do_start();
        chk("t1_fill", phase, 1);
        chk("t1_fill_lock", {fill_en, door_lock}, 2'b11);
        level = 10'd512; cyc(1);
        chk("t1_agit", phase, 3);
        chk("t1_agit_cw", {drum_en, drum_dir}, 2'b10);
        ticks(4);
        chk("t1_agit_off", {drum_en, drum_dir}, 2'b00);
        ticks(1);
        chk("t1_agit_ccw", {drum_en, drum_dir}, 2'b11);
        ticks(5);
        chk("t1_agit_cw2", {drum_en, drum_dir}, 2'b10);
        ticks(10);
        chk("t1_agit_hold", phase, 3);
        cyc(1);
        chk("t1_drain", {phase, drain_en}, {4'd4, 1'b1});
        level = 10'd0; cyc(1);
        chk("t1_spin", {phase, spin_en, drain_en}, {4'd5, 2'b11});
        ticks(8); cyc(1);
        chk("t1_rinse_fill", phase, 1);
        level = 10'd512; cyc(1);
        chk("t1_rinse_agit", phase, 3);
        ticks(10); cyc(1);
        chk("t1_rinse_drain", phase, 4);
        level = 10'd0; cyc(1);
        chk("t1_rinse_spin", phase, 5);
        ticks(8); cyc(1);
        chk("t1_done", {phase, done, door_lock}, {4'd7, 2'b10});
        do_clear();
        chk("t1_idle", phase, 0);

        // Fill full and fill timeout in the same cycle: full wins
        rinse_cnt = 2'd0;
        do_start();
        ticks(30);
        chk("full_wins_pre", phase, 1);
        level = 10'd512; cyc(1);
        chk("full_wins", phase, 3);
        abort = 1'b1; cyc(1); abort = 1'b0;
        level = 10'd0; cyc(1);
        chk("full_wins_idle", phase, 0);

        // Fill timeout
        do_start();
        ticks(30); cyc(1);
        chk("fill_timeout", {phase, fault, fault_code}, {4'd8, 1'b1, 3'd1});
        do_clear();
        chk("fill_to_clear", {phase, fault, fault_code}, 0);

        // Heat timeout
        heat_req = 1'b1; temp_reached = 1'b0;
        do_start();
        level = 10'd512; cyc(1);
        chk("t2_heat", {phase, heat_en, drum_en}, {4'd2, 2'b11});
        ticks(40); cyc(1);
        chk("t2_fault", {phase, fault_code, heat_en, drain_en, door_lock}, {4'd8, 3'd2, 3'b011});
        do_clear();
        chk("t2_clear_wet", phase, 8);
        level = 10'd10; cyc(1);
        chk("t2_dry", {drain_en, door_lock}, 2'b00);
        do_clear();
        chk("t2_idle", {phase, fault, fault_code}, 0);
        heat_req = 1'b0;

        // Unbalance: three rebalances end in a fault
        run_to_spin();
        chk("t3_spin", phase, 5);
        for (int r = 0; r < 3; r++) begin
            ticks(3);
            vibration = 1'b1; cyc(1); vibration = 1'b0;
            chk("t3_rebal", {phase, spin_en, drum_en, drum_dir}, {4'd6, 3'b010});
            ticks(1);
            chk("t3_rebal_dir", drum_dir, 1);
            ticks(4); cyc(1);
            chk("t3_rebal_exit", phase, (r < 2) ? 32'd5 : 32'd8);
        end
        chk("t3_code4", fault_code, 4);
        do_clear();
        chk("t3_idle", phase, 0);

        // Two rebalances then normal completion
        run_to_spin();
        for (int r = 0; r < 2; r++) begin
            ticks(3);
            vibration = 1'b1; cyc(1); vibration = 1'b0;
            ticks(5); cyc(1);
        end
        chk("t3b_back_spin", phase, 5);
        ticks(8); cyc(1);
        chk("t3b_done", {phase, done}, {4'd7, 1'b1});
        do_clear();

        // Pause in AGITATE at timer 7
        do_start();
        level = 10'd512; cyc(1);
        ticks(7);
        pause = 1'b1; cyc(1);
        chk("t4_pause", {phase, fill_en, heat_en, drum_en, spin_en, drain_en, door_lock}, {4'd3, 6'b000001});
        ticks(50);
        chk("t4_paused_phase", {phase, drum_en, door_lock}, {4'd3, 2'b01});
        pause = 1'b0;
        ticks(12); cyc(1);
        chk("t4_before_exit", phase, 3);
        ticks(1); cyc(1);
        chk("t4_exit", phase, 4);

        // Asynchronous reset mid-SPIN
        level = 10'd0; cyc(1);
        ticks(2);
        chk("t6_spin", phase, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rst", {phase, spin_en, drain_en, door_lock, fault, done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);

        // Abort during FILL
        do_start();
        level = 10'd300; cyc(1);
        abort = 1'b1; cyc(1); abort = 1'b0;
        chk("t5_abort", {phase, fill_en, drain_en, door_lock}, {4'd9, 3'b011});
        level = 10'd10; cyc(1);
        chk("t5_idle", {phase, fault, door_lock}, 0);

        // Door opened during AGITATE
        do_start();
        level = 10'd512; cyc(1);
        ticks(3);
        door_closed = 1'b0; cyc(1);
        chk("t6_door", {phase, fault, fault_code, drain_en}, {4'd8, 1'b1, 3'd5, 1'b1});
        door_closed = 1'b1; level = 10'd0; cyc(1);
        do_clear();
        chk("t6_idle", {phase, fault, fault_code}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
